bist_run_arbiter: RTL and testbench
===================================

// Module: bist_run_arbiter
// PURPOSE
//  Shares one BIST pulse-generator controller among NREQ requesters. Picks one requester
//  round-robin, drives the generator's start input, tracks the run via running/bist_end,
//  and returns a done (or err) pulse to the winner. Sits between the block-level BIST
//  requesters and the single pulse-generator controller.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  START_CYC 2   cycles gen_start is held high per launch (>=2; generator detects rising edge)
//  TW       8    width of watchdog counter
//  TIMEOUT  255  watchdog limit in cycles per wait state (<= 2**TW-1)
// PORTS
//  clk           in   1     clock, all logic on posedge
//  reset         in   1     reset, synchronous, active-high
//  req           in   NREQ  level requests; held by requester until its done/err
//  grant         out  NREQ  one-hot owner of generator; zero when idle
//  done          out  NREQ  1-cycle pulse to owner on normal completion
//  err           out  NREQ  1-cycle pulse to owner on watchdog expiry
//  busy          out  1     high while any grant active
//  gen_start     out  1     to generator start input
//  gen_running   in   1     from generator running output
//  gen_bist_end  in   1     from generator bist_end output (level, stays high after run)
// BEHAVIOUR
//  - All outputs registered. Reset: grant=0, done=0, err=0, busy=0, gen_start=0, state=IDLE,
//    rr pointer=NREQ-1 (so req[0] wins first), watchdog=0. Reset mid-run aborts at once;
//    generator is not reset by this block.
//  - FSM: IDLE -> START -> WAIT_RUN -> WAIT_END -> DONE -> IDLE; WAIT_RUN/WAIT_END -> ERR -> IDLE.
//  - IDLE: if req!=0 at edge T, winner = first set bit searching ptr+1, ptr+2, ... (mod NREQ);
//    from T+1: grant=onehot(winner), busy=1, ptr<=winner, enter START.
//  - START: gen_start=1 for exactly START_CYC cycles, then gen_start=0, enter WAIT_RUN, wdog=0.
//  - WAIT_RUN: wait gen_running==1 -> WAIT_END, wdog=0. gen_bist_end ignored here (stale
//    level from previous run).
//  - WAIT_END: wait gen_running==0 && gen_bist_end==1 -> DONE.
//  - DONE (1 cycle): done[winner]=1, grant still held; next cycle grant=0, busy=0, IDLE.
//  - ERR (1 cycle): err[winner]=1, grant held; next cycle grant=0, busy=0, IDLE.
//  - Watchdog: increments each cycle in WAIT_RUN/WAIT_END; when wdog==TIMEOUT and exit
//    condition false -> ERR. Exit condition true in same cycle as expiry -> normal path wins.
//  - At least one IDLE cycle between runs; done and err never both high; never two grant bits.
//  - req dropped mid-run: run completes normally, done still pulses to that index.
//  - req bits of non-owners ignored until IDLE; ptr only changes on a new grant.
// CONFIGURATION
//  BIST_ARB_TIMEOUT_EN defined: watchdog, ERR state and err outputs as above.
//  Not defined: no watchdog logic, WAIT_RUN/WAIT_END wait indefinitely, err tied to 0.
// TESTING (generator model = pulse controller with N_MAX=8, M_MAX=9)
//  1 req=0001 from idle at edge T -> grant=0001,busy=1 at T+1; gen_start high T+1..T+2;
//    single done[0] pulse after bist_end rises with running low; grant=0 next cycle.
//  2 req=1111 held -> grants in order 0001,0010,0100,1000,0001; each separated by DONE+IDLE.
//  3 last owner=2, req=0101 -> next grant=0001 (search 3,0); then 0100.
//  4 TIMEOUT_EN, TIMEOUT=20, generator never raises running -> err[k] pulse 20 cycles
//    after WAIT_RUN entry, done stays 0, busy=0 the cycle after.
//  5 reset asserted in WAIT_END -> next cycle grant=0,gen_start=0,busy=0; next req=1111
//    grants 0001.
//  6 macro undefined, stuck generator -> busy stays 1 for 1000 cycles, err stays 0.

Source files
------------

// File: rtl/bist_run_arbiter.sv
// bist_run_arbiter
//   Shares one BIST pulse-generator controller among NREQ requesters.
//   A round-robin pick launches the generator with a START_CYC-cycle gen_start
//   pulse. The block then follows gen_running/gen_bist_end and returns a one-cycle
//   done pulse to the owner. All outputs are registered.
//   Optional build macro: BIST_ARB_TIMEOUT_EN adds a per-wait-state watchdog,
//   an ERR state and the err pulses. Without it the waits are unbounded and
//   o_err is tied low.
module bist_run_arbiter #(
  parameter int NREQ      = 4,
  parameter int START_CYC = 2,
  parameter int TW        = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [NREQ-1:0] o_done,
  output logic [NREQ-1:0] o_err,
  output logic            o_busy,
  output logic            o_gen_start,
  input  logic            i_gen_running,
  input  logic            i_gen_bist_end
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SCW = $clog2(START_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_RUN = 3'd2,
    S_WAIT_END = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  // Round-robin search: first set request bit at ptr+1, ptr+2, ... (mod NREQ).
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    logic [IW-1:0] idx_v;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      idx_v = IW'(idx);
      if (!found && req[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // One-hot expansion of a requester index.
  function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  state_t          r_state,     w_state_nxt;
  logic [IW-1:0]   r_ptr,       w_ptr_nxt;
  logic [SCW-1:0]  r_start_cnt, w_start_cnt_nxt;
  logic [NREQ-1:0] r_grant,     w_grant_nxt;
  logic [NREQ-1:0] r_done,      w_done_nxt;
  logic            r_busy,      w_busy_nxt;
  logic            r_gen_start, w_gen_start_nxt;
  logic [IW-1:0]   w_win;
`ifdef BIST_ARB_TIMEOUT_EN
  logic [TW-1:0]   r_wdog,      w_wdog_nxt;
  logic [NREQ-1:0] r_err,       w_err_nxt;
`endif

  assign w_win = rr_pick(i_req, r_ptr);

  // Next-state and next-output decode; every target gets a default first.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_start_cnt_nxt = r_start_cnt;
    w_grant_nxt     = r_grant;
    w_done_nxt      = {NREQ{1'b0}};
    w_busy_nxt      = r_busy;
    w_gen_start_nxt = 1'b0;
`ifdef BIST_ARB_TIMEOUT_EN
    w_wdog_nxt      = r_wdog;
    w_err_nxt       = {NREQ{1'b0}};
`endif
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_nxt     = S_START;
          w_ptr_nxt       = w_win;
          w_grant_nxt     = to_onehot(w_win);
          w_busy_nxt      = 1'b1;
          w_gen_start_nxt = 1'b1;
          w_start_cnt_nxt = {SCW{1'b0}};
        end else begin
          w_grant_nxt = {NREQ{1'b0}};
          w_busy_nxt  = 1'b0;
        end
      end
      S_START: begin
        // The launch edge already counted as the first gen_start cycle.
        if (r_start_cnt == SCW'(START_CYC - 1)) begin
          w_state_nxt     = S_WAIT_RUN;
          w_gen_start_nxt = 1'b0;
          w_start_cnt_nxt = {SCW{1'b0}};
`ifdef BIST_ARB_TIMEOUT_EN
          w_wdog_nxt      = {TW{1'b0}};
`endif
        end else begin
          w_start_cnt_nxt = r_start_cnt + 1'b1;
          w_gen_start_nxt = 1'b1;
        end
      end
      S_WAIT_RUN: begin
        // bist_end is still high from the previous run here, so only running counts.
        if (i_gen_running) begin
          w_state_nxt = S_WAIT_END;
`ifdef BIST_ARB_TIMEOUT_EN
          w_wdog_nxt  = {TW{1'b0}};
        end else if (r_wdog == TW'(TIMEOUT)) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = r_grant;
        end else begin
          w_wdog_nxt  = r_wdog + 1'b1;
        end
`else
        end else begin
          w_state_nxt = S_WAIT_RUN;
        end
`endif
      end
      S_WAIT_END: begin
        // A completion in the same cycle as watchdog expiry takes the normal path.
        if (!i_gen_running && i_gen_bist_end) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
`ifdef BIST_ARB_TIMEOUT_EN
        end else if (r_wdog == TW'(TIMEOUT)) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = r_grant;
        end else begin
          w_wdog_nxt  = r_wdog + 1'b1;
        end
`else
        end else begin
          w_state_nxt = S_WAIT_END;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = {NREQ{1'b0}};
        w_busy_nxt  = 1'b0;
      end
`ifdef BIST_ARB_TIMEOUT_EN
      S_ERR: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = {NREQ{1'b0}};
        w_busy_nxt  = 1'b0;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = {NREQ{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_start_cnt <= {SCW{1'b0}};
      r_grant     <= {NREQ{1'b0}};
      r_done      <= {NREQ{1'b0}};
      r_busy      <= 1'b0;
      r_gen_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_start_cnt <= w_start_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_gen_start <= w_gen_start_nxt;
    end
  end

`ifdef BIST_ARB_TIMEOUT_EN
  // Watchdog count and err pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog <= {TW{1'b0}};
      r_err  <= {NREQ{1'b0}};
    end else begin
      r_wdog <= w_wdog_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = {NREQ{1'b0}};
`endif

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_gen_start = r_gen_start;

endmodule

// File: tb/tb_bist_run_arbiter.sv
// Self-checking bench for bist_run_arbiter: randomized runs with a scripted
// generator, checked against a round-robin model of the requester rotation.
module tb_bist_run_arbiter;

  localparam int NREQ      = 4;
  localparam int START_CYC = 2;
  localparam int TW        = 8;
  localparam int TIMEOUT   = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant, done, err;
  logic            busy, gen_start;
  logic            gen_running, gen_bist_end;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ptr;

  bist_run_arbiter #(
    .NREQ(NREQ), .START_CYC(START_CYC), .TW(TW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .i_req(req), .o_grant(grant), .o_done(done),
    .o_err(err), .o_busy(busy), .o_gen_start(gen_start),
    .i_gen_running(gen_running), .i_gen_bist_end(gen_bist_end)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rotation: first requester after the previous winner, wrapping around.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] sh;
    int idx;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (p + i) % NREQ;
      sh  = r >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << w;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_gen_start"}, 32'(gen_start), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One arbitration + run. Entered just after a sample that showed the arbiter idle.
  // With stuck=1 it returns right after the launch, generator silent.
  task automatic run_one(input logic [NREQ-1:0] rq, input int d_run, input int d_end,
                         input int gap, input bit drop_owner, input bit stuck);
    int w;
    logic [NREQ-1:0] oh;
    req = rq;
    w = pick(rq, model_ptr);
    model_ptr = w;
    oh = onehot(w);
    tick();
    check_eq("launch_grant", 32'(grant), 32'(oh));
    check_eq("launch_busy", 32'(busy), 32'd1);
    check_eq("launch_gen_start", 32'(gen_start), 32'd1);
    for (int i = 1; i < START_CYC; i++) begin
      tick();
      check_eq("start_hold", 32'(gen_start), 32'd1);
      check_eq("start_grant", 32'(grant), 32'(oh));
    end
    tick();
    check_eq("start_low", 32'(gen_start), 32'd0);
    check_eq("wait_grant", 32'(grant), 32'(oh));
    // Non-owner request noise while the run is in flight.
    req = NREQ'($urandom) | oh;
    if (stuck) return;
    for (int i = 0; i < d_run; i++) begin
      tick();
      check_eq("wait_run_done", 32'(done), 32'd0);
      check_eq("wait_run_err", 32'(err), 32'd0);
      check_eq("wait_run_grant", 32'(grant), 32'(oh));
    end
    gen_running  = 1'b1;
    gen_bist_end = 1'b0;
    if (drop_owner) req = req & ~oh;
    tick();
    check_eq("run_seen_err", 32'(err), 32'd0);
    check_eq("run_seen_done", 32'(done), 32'd0);
    for (int i = 0; i < d_end; i++) begin
      tick();
      check_eq("wait_end_done", 32'(done), 32'd0);
      check_eq("wait_end_grant", 32'(grant), 32'(oh));
    end
    gen_running = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      check_eq("gap_done", 32'(done), 32'd0);
    end
    gen_bist_end = 1'b1;
    tick();
    check_eq("done_pulse", 32'(done), 32'(oh));
    check_eq("done_err", 32'(err), 32'd0);
    check_eq("done_grant", 32'(grant), 32'(oh));
    check_eq("done_busy", 32'(busy), 32'd1);
    tick();
    check_idle("post_done");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gen_running = 1'b0;
    tick();
    reset = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic busy_all;
    logic err_any;
    logic grant_ok;
    reset = 1'b1;
    req = '0;
    gen_running = 1'b0;
    gen_bist_end = 1'b1;
    model_ptr = NREQ - 1;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle_noreq");
    end

    // All four requesting: full rotation starting at index 0.
    for (int i = 0; i < 5; i++)
      run_one(4'b1111, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 0, 1'b0, 1'b0);

    // Single requester, fixed timing.
    run_one(4'b0001, 3, 4, 1, 1'b0, 1'b0);

    // Last owner 2 with req 0101: search 3,0 -> 0, then 2.
    run_one(4'b0100, 2, 2, 0, 1'b0, 1'b0);
    run_one(4'b0101, 1, 1, 0, 1'b0, 1'b0);
    check_eq("rr_after_2", 32'(model_ptr), 32'd0);
    run_one(4'b0101, 1, 1, 0, 1'b0, 1'b0);

    // Randomized runs, including owner dropping its request mid-run.
    for (int i = 0; i < 40; i++)
      run_one(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0);

`ifdef BIST_ARB_TIMEOUT_EN
    // Exit exactly at watchdog expiry takes the normal path, in both wait states.
    run_one(4'b1111, TIMEOUT, 0, 0, 1'b0, 1'b0);
    run_one(4'b1111, 0, TIMEOUT, 0, 1'b0, 1'b0);
    // Silent generator: err after the watchdog runs out in WAIT_RUN.
    run_one(4'b0010, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check_eq("wdog_no_err", 32'(err), 32'd0);
    end
    tick();
    check_eq("wdog_err", 32'(err), 32'(onehot(model_ptr)));
    check_eq("wdog_done", 32'(done), 32'd0);
    check_eq("wdog_grant", 32'(grant), 32'(onehot(model_ptr)));
    tick();
    check_idle("post_err");
`else
    // Silent generator with no watchdog: the run never ends.
    run_one(4'b0010, 0, 0, 0, 1'b0, 1'b1);
    busy_all = 1'b1;
    err_any  = 1'b0;
    grant_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      busy_all = busy_all & busy;
      err_any  = err_any | (|err) | (|done);
      grant_ok = grant_ok & (grant == onehot(model_ptr));
    end
    check_eq("stuck_busy", 32'(busy_all), 32'd1);
    check_eq("stuck_err", 32'(err_any), 32'd0);
    check_eq("stuck_grant", 32'(grant_ok), 32'd1);
    do_reset();
    check_idle("stuck_reset");
`endif

    // Reset while in WAIT_END aborts the run; rotation restarts at 0.
    run_one(4'b0100, 0, 0, 0, 1'b0, 1'b1);
    gen_running = 1'b1;
    gen_bist_end = 1'b0;
    tick();
    tick();
    do_reset();
    check_idle("reset_wait_end");
    gen_bist_end = 1'b1;
    run_one(4'b1111, 2, 3, 0, 1'b0, 1'b0);
    check_eq("post_reset_owner", 32'(model_ptr), 32'd0);

    // Reset while gen_start is high.
    req = 4'b1000;
    tick();
    check_eq("pre_reset_gen_start", 32'(gen_start), 32'd1);
    do_reset();
    check_idle("reset_start");
    run_one(4'b1010, 1, 1, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
